data_sram_responder: RTL and testbench

//   Target-side responder for the core's data SRAM port (en/wen/addr/wdata -> rdata).

---
 rtl/data_sram_responder_if.sv | 27 ++
 rtl/data_sram_responder.sv | 97 +++++++++
 tb/tb_data_sram_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Data SRAM port plus the serial TX byte link, bundled so the CPU wrapper and
// the responder share one definition of the bus.
interface data_sram_responder_if #(
  parameter int DATA_WD = 64,
  parameter int ADDR_WD = 64
);
  logic                   sram_en;
  logic [DATA_WD/8-1:0]   sram_wen;
  logic [ADDR_WD-1:0]     sram_addr;
  logic [DATA_WD-1:0]     sram_wdata;
  logic [DATA_WD-1:0]     sram_rdata;
  // TX link: a byte transfers on every rising edge where tx_valid & tx_ready;
  // tx_valid never waits on tx_ready, and tx_data holds while valid & !ready.
  logic                   tx_valid;
  logic [7:0]             tx_data;
  logic                   tx_ready;

  modport master (
    output sram_en, sram_wen, sram_addr, sram_wdata, tx_ready,
    input  sram_rdata, tx_valid, tx_data
  );

  modport slave (
    input  sram_en, sram_wen, sram_addr, sram_wdata, tx_ready,
    output sram_rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/data_sram_responder.sv
// Target-side responder for the core's data SRAM port: byte-lane RAM, a 64-bit
// real-time counter and a serial TX register backed by a small byte FIFO.
module data_sram_responder #(
  parameter int                 DATA_WD     = 64,
  parameter int                 ADDR_WD     = 64,
  parameter logic [ADDR_WD-1:0] RAM_BASE    = 64'h8000_0000,
  parameter int                 RAM_DEPTH   = 4096,
  parameter logic [ADDR_WD-1:0] RTC_ADDR    = 64'ha000_0048,
  parameter logic [ADDR_WD-1:0] SERIAL_ADDR = 64'ha000_03f8,
  parameter int                 FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  data_sram_responder_if.slave    bus,
  output logic                    access_err,
  output logic                    tx_overflow
);
  localparam int WEN_WD = DATA_WD / 8;
  localparam int IDX_WD = $clog2(RAM_DEPTH);
  localparam int PTR_WD = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WD-1:0] RAM_END = RAM_BASE + ADDR_WD'(RAM_DEPTH) * ADDR_WD'(8);

  logic [ADDR_WD-1:0] word_addr;
  logic [ADDR_WD-1:0] ram_off;
  logic [IDX_WD-1:0]  ram_idx;
  logic               hit_ram, hit_rtc, hit_serial, hit_none;
  logic               rd_en, wr_en;
  logic [DATA_WD-1:0] rd_word;
  logic [63:0]        rtc;

  logic [DATA_WD-1:0] ram [RAM_DEPTH];
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_WD:0]    head, tail, count;
  logic               full, pop, push_req, push_ok;
  logic               unused_off;

  assign word_addr  = bus.sram_addr & ~ADDR_WD'(7);
  assign ram_off    = word_addr - RAM_BASE;
  assign ram_idx    = ram_off[IDX_WD+2:3];
  assign unused_off = ^{ram_off[ADDR_WD-1:IDX_WD+3], ram_off[2:0]};

  assign hit_ram    = (word_addr >= RAM_BASE) && (word_addr < RAM_END);
  assign hit_rtc    = (word_addr == RTC_ADDR);
  assign hit_serial = (word_addr == SERIAL_ADDR);
  assign hit_none   = !(hit_ram || hit_rtc || hit_serial);

  assign wr_en = bus.sram_en && (|bus.sram_wen);
  assign rd_en = bus.sram_en && !(|bus.sram_wen);

  // Wrap-bit pointers: full and empty differ only in the extra MSB.
  assign count    = tail - head;
  assign full     = (count == (PTR_WD+1)'(FIFO_DEPTH));
  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = bus.tx_valid ? fifo_mem[head[PTR_WD-1:0]] : 8'h00;
  assign pop      = bus.tx_valid && bus.tx_ready;
  assign push_req = wr_en && hit_serial && bus.sram_wen[0];
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    rd_word = '0;
    if (hit_ram)         rd_word = ram[ram_idx];
    else if (hit_rtc)    rd_word = DATA_WD'(rtc);
    else if (hit_serial) rd_word = DATA_WD'(count);
  end

  always_ff @(posedge clk) begin
    if (wr_en && hit_ram) begin
      for (int i = 0; i < WEN_WD; i++) begin
        if (bus.sram_wen[i]) ram[ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
    end
  end

  // When full with a pop, tail aliases head; the head byte is already on
  // tx_data this cycle, so overwriting its slot at the edge is safe.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail[PTR_WD-1:0]] <= bus.sram_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.sram_rdata <= '0;
      rtc            <= '0;
      head           <= '0;
      tail           <= '0;
      access_err     <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      rtc <= rtc + 64'd1;
      if (rd_en) bus.sram_rdata <= rd_word;
      if (bus.sram_en && hit_none) access_err <= 1'b1;
      if (pop) head <= head + 1'b1;
      if (push_ok) tail <= tail + 1'b1;
      if (push_req && !push_ok) tx_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: reset values, RTC timing, RAM table, serial
// FIFO ordering/overflow and asynchronous reset mid-transfer.
module tb_data_sram_responder;
  localparam logic [63:0] RTC_ADDR    = 64'ha000_0048;
  localparam logic [63:0] SERIAL_ADDR = 64'ha000_03f8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic access_err, tx_overflow;

  data_sram_responder_if #(.DATA_WD(64), .ADDR_WD(64)) bus ();

  data_sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .access_err (access_err),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [63:0] last_rd = '0;
  logic        exp_err = 1'b0;
  logic        exp_ovf = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.sram_en    = 1'b0;
    bus.sram_wen   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
  endtask

  // One clock: check TX head before the edge, advance the models, then check
  // registered outputs after the edge.
  task automatic cycle();
    int   sz;
    logic pop_now, push_now, is_rd;
    sz = tx_q.size();
    chk("tx_valid", 64'(bus.tx_valid), 64'(sz != 0));
    if (sz != 0) chk("tx_data", 64'(bus.tx_data), 64'(tx_q[0]));
    pop_now  = (sz != 0) && bus.tx_ready;
    push_now = bus.sram_en && bus.sram_wen[0] && ((bus.sram_addr & ~64'h7) == SERIAL_ADDR);
    is_rd    = bus.sram_en && (bus.sram_wen == '0);
    @(posedge clk); #1;
    if (pop_now) void'(tx_q.pop_front());
    if (push_now) begin
      if (sz < 8 || pop_now) tx_q.push_back(bus.sram_wdata[7:0]);
      else exp_ovf = 1'b1;
    end
    if (is_rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL exp_q: read with no expectation at %0t", $time);
      end else last_rd = exp_q.pop_front();
    end
    chk("rdata", bus.sram_rdata, last_rd);
    chk("access_err", 64'(access_err), 64'(exp_err));
    chk("tx_overflow", 64'(tx_overflow), 64'(exp_ovf));
  endtask

  task automatic acc(input logic [7:0] wen, input logic [63:0] addr, input logic [63:0] wdata);
    bus.sram_en    = 1'b1;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    cycle();
    set_idle();
  endtask

  task automatic rd(input logic [63:0] addr, input logic [63:0] exp);
    exp_q.push_back(exp);
    acc(8'h00, addr, 64'h0);
  endtask

  initial begin
    set_idle();
    bus.tx_ready = 1'b0;
    vecs[0] = '{8'hFF, 64'h8000_0010, 64'h0,                   64'h0,                   1'b0};
    vecs[1] = '{8'h0F, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0,                   1'b0};
    vecs[2] = '{8'h00, 64'h8000_0010, 64'h0,                   64'h0000_0000_5566_7788, 1'b0};
    vecs[3] = '{8'hFF, 64'h8000_0000, 64'h1,                   64'h0,                   1'b0};
    vecs[4] = '{8'h00, 64'h8000_0000, 64'h0,                   64'h1,                   1'b0};
    vecs[5] = '{8'hFF, 64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                   1'b0};
    vecs[6] = '{8'h00, 64'h8000_7FFC, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[7] = '{8'hF0, 64'h8000_0013, 64'hAABB_CCDD_0000_0000, 64'h0,                   1'b0};
    vecs[8] = '{8'h00, 64'h8000_8000, 64'h0,                   64'h0,                   1'b1};
    vecs[9] = '{8'h00, 64'h8000_0010, 64'h0,                   64'hAABB_CCDD_5566_7788, 1'b1};

    // Reset values while reset is held
    #23;
    chk("rst_rdata", bus.sram_rdata, 64'h0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'h0);
    chk("rst_err", 64'(access_err), 64'h0);
    chk("rst_ovf", 64'(tx_overflow), 64'h0);

    // Release between edges; the tenth edge after release reads 9
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (9) cycle();
    rd(RTC_ADDR, 64'd9);
    acc(8'hFF, RTC_ADDR, 64'h0);
    rd(RTC_ADDR, 64'd11);
    rd(RTC_ADDR + 64'd4, 64'd12);

    // RAM / decode table
    for (int i = 0; i < 10; i++) begin
      exp_err = vecs[i].exp_err;
      if (vecs[i].wen == 8'h00) rd(vecs[i].addr, vecs[i].exp_rd);
      else acc(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
    end
    rd(64'h8000_0000, 64'h1);

    // Serial: "ABC" held, lane-1-only write ignored, then drain
    bus.tx_ready = 1'b0;
    acc(8'h01, SERIAL_ADDR, 64'h41);
    acc(8'h01, SERIAL_ADDR, 64'h42);
    acc(8'h01, SERIAL_ADDR + 64'd7, 64'h43);
    cycle();
    cycle();
    acc(8'h02, SERIAL_ADDR, 64'h5A5A);
    rd(SERIAL_ADDR, 64'd3);
    bus.tx_ready = 1'b1;
    repeat (4) cycle();

    // Fill, push+pop while full, dropped push, drain
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) acc(8'h01, SERIAL_ADDR, 64'(8'h10 + i));
    rd(SERIAL_ADDR, 64'd8);
    bus.tx_ready = 1'b1;
    acc(8'h01, SERIAL_ADDR, 64'h18);
    bus.tx_ready = 1'b0;
    rd(SERIAL_ADDR, 64'd8);
    acc(8'hFF, SERIAL_ADDR, 64'h19);
    rd(SERIAL_ADDR, 64'd8);
    bus.tx_ready = 1'b1;
    repeat (9) cycle();

    // Asynchronous reset with five bytes queued
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) acc(8'h01, SERIAL_ADDR, 64'($urandom_range(0, 255)));
    rd(SERIAL_ADDR, 64'd5);
    #3;
    reset = 1'b0;
    #1;
    chk("async_tx_valid", 64'(bus.tx_valid), 64'h0);
    chk("async_tx_data", 64'(bus.tx_data), 64'h0);
    chk("async_rdata", bus.sram_rdata, 64'h0);
    chk("async_err", 64'(access_err), 64'h0);
    chk("async_ovf", 64'(tx_overflow), 64'h0);
    tx_q.delete();
    exp_q.delete();
    last_rd = '0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cycle();
    rd(64'h8000_0000, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
